// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
// Holds the FSM state encoding, the slice width and the operation
// encoding used on op_sub / the slice m input.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_EXEC = ST_EXEC,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit add/subtract slice with an explicit carry-in so that
// several slices (or one slice reused over time) can be chained.
//   a, b : 4-bit operands
//   m    : 0 = add, 1 = subtract (inverts b; the +1 comes in through cin)
//   cin  : carry into bit 0
//   s    : 4-bit sum
//   cout : carry out of bit 3
//   c3   : carry into bit 3 (cout ^ c3 gives signed overflow of the slice)
module nibble_addsub
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                m,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W-1:0] b_eff;
  logic [NIBBLE_W-1:0] low_sum;
  logic [NIBBLE_W:0]   full_sum;

  always_comb begin
    b_eff    = b ^ {NIBBLE_W{m}};
    // Sum of the lower three bits only; its MSB is the carry into bit 3.
    low_sum  = {1'b0, a[2:0]} + {1'b0, b_eff[2:0]} + {3'b000, cin};
    full_sum = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
    s        = full_sum[NIBBLE_W-1:0];
    cout     = full_sum[NIBBLE_W];
    c3       = low_sum[NIBBLE_W-1];
  end

endmodule

// File: rtl/nibble_serial_alu.sv
// Multi-nibble add/subtract sequencer. Wide operands are accepted over a
// valid/ready handshake, processed one 4-bit nibble per clock (LSB first)
// through a single nibble_addsub slice with the carry chained in a register,
// and the result is offered over a second valid/ready handshake.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high; valid may not depend on ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   op_a, op_b        W-bit operands, W = 4*NIBBLES
//   op_sub            0 = A+B, 1 = A-B
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   result            W-bit sum/difference modulo 2^W
//   carry             carry out of MSB (subtract: 1 = no borrow)
//   overflow          signed overflow of the W-bit operation
//   zero              result == 0
//   busy              high in EXEC or DONE
// result/carry/overflow/zero hold their last values outside DONE; result
// nibbles change progressively during EXEC, so qualify with out_valid.
module nibble_serial_alu
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NIBBLES-1:0]    op_a,
  input  logic [4*NIBBLES-1:0]    op_b,
  input  logic                    op_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NIBBLES-1:0]    result,
  output logic                    carry,
  output logic                    overflow,
  output logic                    zero,
  output logic                    busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t state_q, state_d;

  logic [W-1:0]        a_q, b_q, result_q, result_merged;
  logic                sub_q;
  logic                carry_chain_q;
  logic                carry_q, overflow_q, zero_q;
  logic [IDX_W-1:0]    idx_q;

  logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
  logic                cout_nib, c3_nib;
  logic                accept, last_nib;

  // ---------------------------------------------------------------------
  // Nibble selection and result merge (constant-index loops keep every
  // part-select static).
  // ---------------------------------------------------------------------
  always_comb begin
    a_nib         = '0;
    b_nib         = '0;
    result_merged = result_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
        result_merged[i*NIBBLE_W +: NIBBLE_W] = s_nib;
      end
    end
  end

  nibble_addsub u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .m    (sub_q),
    .cin  (carry_chain_q),
    .s    (s_nib),
    .cout (cout_nib),
    .c3   (c3_nib)
  );

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  assign accept   = (state_q == S_IDLE) && in_valid;
  assign last_nib = (state_q == S_EXEC) && (idx_q == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept)    state_d = S_EXEC;
      S_EXEC: if (last_nib)  state_d = S_DONE;
      // in_valid is deliberately ignored here: a new operand set can only
      // be taken in the IDLE cycle that follows the output transfer.
      S_DONE: if (out_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q           <= '0;
      b_q           <= '0;
      sub_q         <= OP_ADD;
      carry_chain_q <= 1'b0;
      idx_q         <= '0;
      result_q      <= '0;
      carry_q       <= 1'b0;
      overflow_q    <= 1'b0;
      zero_q        <= 1'b0;
    end else begin
      if (accept) begin
        a_q           <= op_a;
        b_q           <= op_b;
        sub_q         <= op_sub;
        // Subtract is A + ~B + 1; the +1 enters as the initial carry.
        carry_chain_q <= op_sub;
        idx_q         <= '0;
      end
      if (state_q == S_EXEC) begin
        result_q      <= result_merged;
        carry_chain_q <= cout_nib;
        idx_q         <= idx_q + IDX_W'(1);
        if (last_nib) begin
          carry_q    <= cout_nib;
          overflow_q <= c3_nib ^ cout_nib;
          // Evaluated on the merged value so it matches the completed
          // result register from the first DONE cycle onwards.
          zero_q     <= (result_merged == '0);
        end
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
